// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//   Two requesters share one 32-bit ALU (alu_32bit). The arbiter grants one
//   requester at a time. It latches that requester's operands and
//   opcode, and captures the ALU outputs into response registers. Those
//   registers are held until the granted requester consumes the result.
//   Priority between the requesters alternates on response completion.
//
// Optional feature (compile-time macro ALU_ILLEGAL_OP_CHECK_EN):
//   When the macro is defined, opcodes 011 and 100 are accepted, but they
//   return result=0, zero=1, over=0, cout=0 and err=1. When the macro is
//   undefined, every opcode goes to the ALU and rsp_err is tied to 0.
//
// Parameters
//   INIT_PRIO   requester (0 or 1) that holds priority after reset
//
// Ports
//   clk                       rising-edge clock
//   reset                     asynchronous, active-high reset
//   req0_valid / req1_valid   requester presents an operation
//   req0_ready / req1_ready   operation accepted this cycle (IDLE only)
//   req0_a/b, req1_a/b        32-bit operands
//   req0_oper / req1_oper     ALU opcode: 000 AND, 001 OR, 010 ADD,
//                             110 SUB, 111 SLT, 101 SHL1
//   rsp0_valid / rsp1_valid   a result is held for that requester
//   rsp0_ready / rsp1_ready   requester consumes the held result
//   rsp_result                registered ALU result
//   rsp_zero/over/cout        registered ALU flags
//   rsp_err                   illegal opcode flag
//
// FSM states
//   state  | meaning
//   IDLE   | wait for a request; grant it and latch its operands
//   EXEC   | latched operands drive the ALU; capture outputs on the edge
//   HOLD   | result held until the granted requester consumes it
// ---------------------------------------------------------------------------

module alu_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  oper,
  output logic [31:0] result,
  output logic        zero,
  output logic        over,
  output logic        cout
);

  logic [32:0] sum;
  logic [32:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  // Subtraction is a + ~b + 1, so cout is the carry out of that addition.
  // It is 1 when there is no borrow.
  assign diff = {1'b0, a} + {1'b0, ~b} + 33'd1;

  always_comb begin
    result = 32'd0;
    over   = 1'b0;
    cout   = 1'b0;
    case (oper)
      3'b000: result = a & b;
      3'b001: result = a | b;
      3'b010: begin
        result = sum[31:0];
        cout   = sum[32];
        over   = (a[31] == b[31]) && (sum[31] != a[31]);
      end
      3'b110: begin
        result = diff[31:0];
        cout   = diff[32];
        over   = (a[31] != b[31]) && (diff[31] != a[31]);
      end
      3'b111: result = {31'd0, ($signed(a) < $signed(b))};
      3'b101: result = {a[30:0], 1'b0};
      default: result = 32'd0;
    endcase
  end

  assign zero = (result == 32'd0);

endmodule

module alu_arbiter #(
  parameter int INIT_PRIO = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [2:0]  req0_oper,
  input  logic [2:0]  req1_oper,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  input  logic        rsp0_ready,
  input  logic        rsp1_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_zero,
  output logic        rsp_over,
  output logic        rsp_cout,
  output logic        rsp_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_HOLD = 2'b10
  } state_t;

  localparam logic INIT_PRIO_BIT = 1'(INIT_PRIO);

  state_t      state;
  logic        prio;
  logic        gnt_id;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [2:0]  oper_q;

  logic [31:0] alu_result;
  logic        alu_zero;
  logic        alu_over;
  logic        alu_cout;

  logic        grant0;
  logic        grant1;
  logic        consume;

  alu_32bit u_alu (
    .a      (a_q),
    .b      (b_q),
    .oper   (oper_q),
    .result (alu_result),
    .zero   (alu_zero),
    .over   (alu_over),
    .cout   (alu_cout)
  );

  // With both requesters valid, the priority holder wins. The two grants
  // are mutually exclusive by construction.
  assign grant0 = req0_valid && (!req1_valid || !prio);
  assign grant1 = req1_valid && (!req0_valid ||  prio);

  assign req0_ready = (state == S_IDLE) && grant0;
  assign req1_ready = (state == S_IDLE) && grant1;

  // Only the granted requester's rsp_ready counts.
  assign consume = gnt_id ? rsp1_ready : rsp0_ready;

`ifdef ALU_ILLEGAL_OP_CHECK_EN
  logic err_q;
  logic illegal;

  assign illegal = (oper_q == 3'b011) || (oper_q == 3'b100);
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      prio       <= INIT_PRIO_BIT;
      gnt_id     <= 1'b0;
      a_q        <= 32'd0;
      b_q        <= 32'd0;
      oper_q     <= 3'd0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp_result <= 32'd0;
      rsp_zero   <= 1'b0;
      rsp_over   <= 1'b0;
      rsp_cout   <= 1'b0;
`ifdef ALU_ILLEGAL_OP_CHECK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (grant0) begin
            gnt_id <= 1'b0;
            a_q    <= req0_a;
            b_q    <= req0_b;
            oper_q <= req0_oper;
            state  <= S_EXEC;
          end else if (grant1) begin
            gnt_id <= 1'b1;
            a_q    <= req1_a;
            b_q    <= req1_b;
            oper_q <= req1_oper;
            state  <= S_EXEC;
          end
        end

        S_EXEC: begin
`ifdef ALU_ILLEGAL_OP_CHECK_EN
          if (illegal) begin
            rsp_result <= 32'd0;
            rsp_zero   <= 1'b1;
            rsp_over   <= 1'b0;
            rsp_cout   <= 1'b0;
            err_q      <= 1'b1;
          end else begin
            rsp_result <= alu_result;
            rsp_zero   <= alu_zero;
            rsp_over   <= alu_over;
            rsp_cout   <= alu_cout;
            err_q      <= 1'b0;
          end
`else
          rsp_result <= alu_result;
          rsp_zero   <= alu_zero;
          rsp_over   <= alu_over;
          rsp_cout   <= alu_cout;
`endif
          rsp0_valid <= !gnt_id;
          rsp1_valid <=  gnt_id;
          state      <= S_HOLD;
        end

        S_HOLD: begin
          if (consume) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            prio       <= !gnt_id;
            state      <= S_IDLE;
          end
        end

        default: begin
          rsp0_valid <= 1'b0;
          rsp1_valid <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule
